uart_rx: RTL

- Receive-side UART. Deserialises an asynchronous 8N1 serial line into bytes: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the existing uart_tx. Same clock domain (50 MHz system clock, 20 ns period), same frame format, same baud divisor.
- Samples each bit at mid-bit. Delivers each byte with a one-cycle done pulse and flags framing errors.

---
 rtl/uart_defs_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Constants and state encoding shared by the UART transmit and receive blocks.
package uart_defs_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done/framing-error pulses.
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 rx_done_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, counters and pulse generation; STOP leaves at mid-stop to catch back-to-back frames
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign data_o      = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
